// File: rtl/fods_pkg.sv
// Shared definitions for the first-order delta-sigma modulator/demodulator pair.
// Holds the CIC accumulator sizing and the output saturate/truncate helper.
package fods_pkg;

    localparam int CIC_ORDER_MAX = 3;
    localparam int WARM_W        = 2;
    localparam int SAT_MAX_W     = 64;

    function automatic int cic_acc_w(input int order, input int dec_log2);
        return order * dec_log2 + 1;
    endfunction

    // Top accumulator bit set means the window was all ones: clamp to full scale.
    function automatic logic [SAT_MAX_W-1:0] sat_trunc(input logic [SAT_MAX_W-1:0] acc,
                                                       input int acc_w,
                                                       input int data_w);
        logic [SAT_MAX_W-1:0] mask;
        mask = '1 >> (SAT_MAX_W - data_w);
        if (acc[acc_w-1]) begin
            return mask;
        end
        return (acc >> (acc_w - 1 - data_w)) & mask;
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (comparator, DPAD pins).
// Clears to 0 on synchronous reset.
module bit_sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/fods_demod.sv
// Delta-sigma receiver: sinc^N CIC decimator turning a 1-bit stream into unsigned PCM.
// Integrators run every enabled cycle; combs run once per R enabled cycles.
module fods_demod
    import fods_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEC_LOG2  = 8,
    parameter int CIC_ORDER = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ds_in,
    output logic              ds_fb,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid
);

    localparam int ACC_W = cic_acc_w(CIC_ORDER, DEC_LOG2);

    if ((ACC_W - 1 < DATA_W) || (ACC_W > SAT_MAX_W) ||
        (CIC_ORDER < 1) || (CIC_ORDER > CIC_ORDER_MAX)) begin : g_bad_params
        $error("fods_demod: illegal CIC_ORDER / DEC_LOG2 / DATA_W combination");
    end

    logic                w_ds_s;
    logic                w_strobe;
    logic                w_warm_done;
    logic                r_ds_fb;
    logic [DEC_LOG2-1:0] r_dec_cnt;
    logic [WARM_W-1:0]   r_warm_cnt;
    logic [ACC_W-1:0]    r_comb_q;
    logic                r_pend;
    logic [DATA_W-1:0]   r_sample;
    logic                r_valid;

    bit_sync_2ff u_sync (
        .i_clk (sys_clk),
        .i_rst (rst),
        .i_d   (ds_in),
        .o_q   (w_ds_s)
    );

    // Feedback to the RC DAC must keep toggling even while decimation is paused.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ds_fb <= 1'b0;
        end else begin
            r_ds_fb <= w_ds_s;
        end
    end

    assign w_strobe    = en & (&r_dec_cnt);
    assign w_warm_done = (r_warm_cnt == WARM_W'(CIC_ORDER));

    for (genvar k = 0; k < CIC_ORDER; k++) begin : g_integ
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] w_add;
        if (k == 0) begin : g_src
            assign w_add = {{(ACC_W-1){1'b0}}, w_ds_s};
        end else begin : g_src
            assign w_add = g_integ[k-1].r_acc;
        end
        always_ff @(posedge sys_clk) begin
            if (rst) begin
                r_acc <= '0;
            end else if (en) begin
                r_acc <= r_acc + w_add;
            end
        end
    end

    // Comb chain sees the last integrator's value before this edge's update.
    for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
        logic [ACC_W-1:0] r_dly;
        logic [ACC_W-1:0] w_in;
        logic [ACC_W-1:0] w_out;
        if (k == 0) begin : g_src
            assign w_in = g_integ[CIC_ORDER-1].r_acc;
        end else begin : g_src
            assign w_in = g_comb[k-1].w_out;
        end
        assign w_out = w_in - r_dly;
        always_ff @(posedge sys_clk) begin
            if (rst) begin
                r_dly <= '0;
            end else if (w_strobe) begin
                r_dly <= w_in;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_dec_cnt  <= '0;
            r_warm_cnt <= '0;
            r_comb_q   <= '0;
            r_pend     <= 1'b0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= r_pend;
            r_pend  <= w_strobe & w_warm_done;
            if (r_pend) begin
                r_sample <= DATA_W'(sat_trunc(SAT_MAX_W'(r_comb_q), ACC_W, DATA_W));
            end
            if (en) begin
                r_dec_cnt <= r_dec_cnt + 1'b1;
            end
            if (w_strobe) begin
                r_comb_q <= g_comb[CIC_ORDER-1].w_out;
                if (!w_warm_done) begin
                    r_warm_cnt <= r_warm_cnt + 1'b1;
                end
            end
        end
    end

    assign ds_fb        = r_ds_fb;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;

endmodule

// File: tb/tb_fods_demod.sv
// Self-checking bench for fods_demod: a triangular-window reference model predicts
// every sample, valid strobe and feedback bit from the driven bitstream.
`timescale 1ns/1ps
module tb_fods_demod;

    localparam int DATA_W    = 16;
    localparam int DEC_LOG2  = 8;
    localparam int CIC_ORDER = 2;
    localparam int R         = 1 << DEC_LOG2;
    localparam int FULL      = R * R;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              en;
    logic              ds_in;
    logic              ds_fb;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;

    int checks = 0;
    int errors = 0;

    fods_demod #(
        .DATA_W    (DATA_W),
        .DEC_LOG2  (DEC_LOG2),
        .CIC_ORDER (CIC_ORDER)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .en           (en),
        .ds_in        (ds_in),
        .ds_fb        (ds_fb),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: xs holds the synchronized bit seen on each enabled edge.
    // A sinc^2 decimator by R is a triangular FIR of length 2R sampled every R bits.
    bit                m_s1, m_s2, m_pend;
    bit                exp_fb, exp_valid;
    logic [DATA_W-1:0] exp_sample = '0;
    logic [DATA_W-1:0] m_pend_val;
    bit                xs[$];
    int                m_strobes;

    function automatic int window_sum(input int n);
        int s, j, w;
        s = 0;
        for (int d = 1; d < 2 * R; d++) begin
            j = n - 1 - d;
            w = (d <= R) ? d : 2 * R - d;
            if (j >= 1 && xs[j-1]) s += w;
        end
        return s;
    endfunction

    always @(posedge sys_clk) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_pend = 0; m_strobes = 0;
            exp_fb = 0; exp_valid = 0; exp_sample = '0;
            xs.delete();
        end else begin
            exp_valid = m_pend;
            if (m_pend) exp_sample = m_pend_val;
            m_pend = 0;
            if (en) begin
                xs.push_back(m_s2);
                if (xs.size() % R == 0) begin
                    int v;
                    m_strobes++;
                    if (m_strobes > CIC_ORDER) begin
                        v = window_sum(xs.size());
                        m_pend = 1;
                        m_pend_val = (v >= FULL) ? {DATA_W{1'b1}} : DATA_W'(v);
                    end
                end
            end
            exp_fb = m_s2;
            m_s2 = m_s1;
            m_s1 = ds_in;
        end
    end

    task automatic apply_reset();
        rst = 1; en = 0; ds_in = 0;
        repeat (2) @(negedge sys_clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; ds_in = 1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (sample_out !== '0 || sample_valid !== 1'b0 || ds_fb !== 1'b0) begin
            errors++;
            $display("FAIL reset: out/valid/fb got %h/%b/%b want 0000/0/0", sample_out, sample_valid, ds_fb);
        end
        rst = 0; en = 0; ds_in = 0;
    endtask

    task automatic test_stream(input logic [3:0] pat, input int plen,
                               input logic [DATA_W-1:0] want, input string name);
        int last_v;
        last_v = -1;
        apply_reset();
        en = 1;
        for (int c = 0; c < 4 * R + 8; c++) begin
            ds_in = pat[c % plen];
            @(negedge sys_clk);
            checks++;
            if (sample_valid !== exp_valid || sample_out !== exp_sample || ds_fb !== exp_fb) begin
                errors++;
                $display("FAIL %s cyc %0d: valid/out/fb got %b/%h/%b want %b/%h/%b", name, c,
                         sample_valid, sample_out, ds_fb, exp_valid, exp_sample, exp_fb);
            end
            if (plen == 1 && pat[0] && c < 4) begin
                checks++;
                if (ds_fb !== (c >= 2)) begin
                    errors++;
                    $display("FAIL %s fb_latency cyc %0d: got %b want %b", name, c, ds_fb, c >= 2);
                end
            end
            if (sample_valid === 1'b1) begin
                if (last_v >= 0) begin
                    checks++;
                    if (c - last_v != R) begin
                        errors++;
                        $display("FAIL %s spacing: got %0d want %0d", name, c - last_v, R);
                    end
                end
                last_v = c;
            end
        end
        checks++;
        if (sample_out !== want) begin
            errors++;
            $display("FAIL %s steady: got %h want %h", name, sample_out, want);
        end
    endtask

    task automatic test_en_pause();
        int nv;
        apply_reset();
        en = 1; ds_in = 1; nv = 0;
        for (int c = 0; c < 3 * R + 2 * R + 8 + 100; c++) begin
            en = !(c >= 3 * R + R / 2 && c < 3 * R + R / 2 + 100);
            @(negedge sys_clk);
            checks++;
            if (sample_valid !== exp_valid || sample_out !== exp_sample || ds_fb !== exp_fb) begin
                errors++;
                $display("FAIL en_pause cyc %0d: valid/out/fb got %b/%h/%b want %b/%h/%b", c,
                         sample_valid, sample_out, ds_fb, exp_valid, exp_sample, exp_fb);
            end
            if (!en && sample_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL en_pause valid_while_low: got %0d want 0", nv);
        end
        checks++;
        if (sample_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL en_pause value: got %h want ffff", sample_out);
        end
    endtask

    task automatic test_en_fall_on_strobe();
        int  nv;
        bit  found;
        apply_reset();
        en = 1; found = 0; nv = 0;
        for (int c = 0; c < 4 * R && !found; c++) begin
            if (c > 3 * R && xs.size() % R == R - 1) begin
                found = 1;
            end else begin
                ds_in = 1'($urandom_range(0, 1));
                @(negedge sys_clk);
                checks++;
                if (sample_valid !== exp_valid || sample_out !== exp_sample) begin
                    errors++;
                    $display("FAIL en_fall pre cyc %0d: valid/out got %b/%h want %b/%h", c,
                             sample_valid, sample_out, exp_valid, exp_sample);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL en_fall timeout: got no strobe cycle want one within %0d cycles", 4 * R);
        end
        @(negedge sys_clk);
        en = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            checks++;
            if (sample_valid !== exp_valid || sample_out !== exp_sample) begin
                errors++;
                $display("FAIL en_fall low cyc %0d: valid/out got %b/%h want %b/%h", c,
                         sample_valid, sample_out, exp_valid, exp_sample);
            end
            if (sample_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 1) begin
            errors++;
            $display("FAIL en_fall valid_count: got %0d want 1", nv);
        end
        en = 1;
    endtask

    task automatic test_reset_mid();
        int  nv;
        bit  found;
        apply_reset();
        en = 1; found = 0; nv = 0;
        for (int c = 0; c < 5 * R && !found; c++) begin
            if (c > 3 * R && xs.size() % R == R - 5) begin
                found = 1;
            end else begin
                ds_in = 1'($urandom_range(0, 1));
                @(negedge sys_clk);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid timeout: got no target cycle want one within %0d cycles", 5 * R);
        end
        rst = 1;
        @(negedge sys_clk);
        rst = 0;
        checks++;
        if (sample_out !== '0 || sample_valid !== 1'b0 || ds_fb !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid clear: out/valid/fb got %h/%b/%b want 0000/0/0",
                     sample_out, sample_valid, ds_fb);
        end
        for (int c = 0; c < 4 * R + 8; c++) begin
            ds_in = ($urandom_range(0, 99) < 70);
            @(negedge sys_clk);
            checks++;
            if (sample_valid !== exp_valid || sample_out !== exp_sample || ds_fb !== exp_fb) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: valid/out/fb got %b/%h/%b want %b/%h/%b", c,
                         sample_valid, sample_out, ds_fb, exp_valid, exp_sample, exp_fb);
            end
            if (c < 2 * R + 8 && sample_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL reset_mid warmup: got %0d valids want 0", nv);
        end
    endtask

    task automatic test_random();
        int dens;
        apply_reset();
        dens = 50;
        for (int c = 0; c < 8 * R; c++) begin
            if (c % R == 0) dens = $urandom_range(0, 100);
            en    = ($urandom_range(0, 9) != 0);
            ds_in = ($urandom_range(0, 99) < dens);
            @(negedge sys_clk);
            checks++;
            if (sample_valid !== exp_valid || sample_out !== exp_sample || ds_fb !== exp_fb) begin
                errors++;
                $display("FAIL random cyc %0d: valid/out/fb got %b/%h/%b want %b/%h/%b", c,
                         sample_valid, sample_out, ds_fb, exp_valid, exp_sample, exp_fb);
            end
        end
    endtask

    initial begin
        logic [3:0] pat;
        rst = 1; en = 0; ds_in = 0;
        test_reset();
        pat = 4'b0000; test_stream(pat, 1, 16'h0000, "const_zero");
        pat = 4'b0001; test_stream(pat, 1, 16'hFFFF, "const_one");
        pat = 4'b0001; test_stream(pat, 2, 16'h8000, "alt_10");
        pat = 4'b0001; test_stream(pat, 4, 16'h4000, "rep_1000");
        test_en_pause();
        test_en_fall_on_strobe();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
